// File: rtl/alu_op_sequencer.sv
// Command-side master for my_alu: one op in flight; rsp_valid rises ALU_LAT+1 clocks after the accepting edge.
// Backpressure: cmd_ready only in IDLE; the response is held stable until rsp_ready. Optional stats: ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
    parameter int WIDTH   = 32,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OPW-1:0]   cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [OPW-1:0]   rsp_op,
    output logic             busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_zero
`endif
);

    localparam int CNTW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [OPW-1:0]   op;
    } rsp_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    rsp_t            rsp_q;

    // Gated by reset so nothing is offered as accepted while reset is held.
    assign cmd_ready  = (state == IDLE) && !reset;
    assign busy       = (state != IDLE);
    assign rsp_result = rsp_q.result;
    assign rsp_zero   = rsp_q.zero;
    assign rsp_op     = rsp_q.op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_q      <= '0;
            rsp_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_opcode <= cmd_op;
                        cnt        <= CNTW'(ALU_LAT);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_q.result <= alu_result;
                        rsp_q.zero   <= alu_zero;
                        rsp_q.op     <= alu_opcode;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic rsp_hs;
    assign rsp_hs = rsp_valid & rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops  <= '0;
            stat_zero <= '0;
        end else if (rsp_hs) begin
            if (stat_ops != 16'hFFFF) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if (rsp_zero && (stat_zero != 16'hFFFF)) begin
                stat_zero <= stat_zero + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a registered (1-clock) ALU model; scoreboard of expected responses.
// Inputs driven and outputs sampled on the falling edge.
module tb_alu_op_sequencer;

    localparam int W = 32;
    localparam int OW = 3;

    typedef struct packed {
        logic [W-1:0]  result;
        logic          zero;
        logic [OW-1:0] op;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [OW-1:0] cmd_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [OW-1:0] alu_opcode;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic [OW-1:0] rsp_op;
    logic          busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]   stat_ops;
    logic [15:0]   stat_zero;
`endif

    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .OPW(OW), .ALU_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
        .busy(busy)
`ifdef ALU_SEQ_STATS_EN
        , .stat_ops(stat_ops), .stat_zero(stat_zero)
`endif
    );

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [OW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Stand-in for my_alu: result registered one clock after its inputs change.
    always @(posedge clk) begin
        alu_result <= alu_fn(alu_a, alu_b, alu_opcode);
        alu_zero   <= (alu_fn(alu_a, alu_b, alu_opcode) == '0);
    end

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op,
                        input logic [W-1:0] er, input logic ez, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        for (int i = 0; i < 30; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            sb.push_back('{result: er, zero: ez, op: op});
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got, output exp_t seen);
        got = 1'b0;
        seen = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                seen = '{result: rsp_result, zero: rsp_zero, op: rsp_op};
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (alu_a !== '0) $display("FAIL reset_alu_a got %0h want 0", alu_a); else passes++;
        checks++; if ({rsp_result, rsp_zero, rsp_op} !== '0) $display("FAIL reset_rsp got %0h want 0", {rsp_result, rsp_zero, rsp_op}); else passes++;
        @(negedge clk);
    endtask

    task automatic test_add_latency();
        bit ok, got;
        exp_t e, s;
        send(32'd1, 32'd1, 3'd0, 32'd2, 1'b0, ok);
        checks++; if (!ok) $display("FAIL add_accept got timeout want accept"); else passes++;
        checks++; if ({alu_a, alu_b, alu_opcode} !== {32'd1, 32'd1, 3'd0})
            $display("FAIL add_alu_regs got %0h/%0h/%0h want 1/1/0", alu_a, alu_b, alu_opcode); else passes++;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0)
            $display("FAIL add_after_E got v=%b busy=%b rdy=%b want 0/1/0", rsp_valid, busy, cmd_ready); else passes++;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL add_after_E1 got %b want 0", rsp_valid); else passes++;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL add_after_E2 got %b want 1", rsp_valid); else passes++;
        wait_rsp(got, s);
        checks++;
        if (!got || sb.size() == 0) $display("FAIL add_rsp got timeout want response");
        else begin
            e = sb.pop_front();
            if (s !== e) $display("FAIL add_rsp got %0h want %0h", s, e); else passes++;
        end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL add_idle got v=%b busy=%b want 0/0", rsp_valid, busy); else passes++;
        checks++; if (alu_a !== 32'd1) $display("FAIL add_alu_hold got %0h want 1", alu_a); else passes++;
    endtask

    task automatic test_sub_zero();
        bit ok, got;
        exp_t e, s;
        send(32'd5, 32'd5, 3'd1, 32'd0, 1'b1, ok);
        wait_rsp(got, s);
        checks++;
        if (!ok || !got || sb.size() == 0) $display("FAIL sub_zero got timeout want response");
        else begin
            e = sb.pop_front();
            if (s !== e) $display("FAIL sub_zero got %0h want %0h", s, e); else passes++;
        end
        send(32'd8, 32'd0, 3'd1, 32'd8, 1'b0, ok);
        wait_rsp(got, s);
        checks++;
        if (!ok || !got || sb.size() == 0) $display("FAIL sub_nonzero got timeout want response");
        else begin
            e = sb.pop_front();
            if (s !== e) $display("FAIL sub_nonzero got %0h want %0h", s, e); else passes++;
        end
    endtask

    task automatic test_backpressure();
        bit ok, got;
        exp_t e, s;
        int bad;
        send(32'd10, 32'd3, 3'd1, 32'd7, 1'b0, ok);
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 32'h55; cmd_b = 32'h22; cmd_op = 3'd0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || rsp_result !== 32'd7 || rsp_op !== 3'd1 || cmd_ready || alu_a !== 32'd10) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else passes++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bp_release got rdy=%b v=%b want 1/0", cmd_ready, rsp_valid); else passes++;
        e = '{result: 32'd7, zero: 1'b0, op: 3'd1};
        void'(sb.pop_front());
        @(posedge clk);
        sb.push_back('{result: 32'h77, zero: 1'b0, op: 3'd0});
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (alu_a !== 32'h55 || busy !== 1'b1) $display("FAIL bp_second_accept got a=%0h busy=%b want 55/1", alu_a, busy); else passes++;
        wait_rsp(got, s);
        checks++;
        if (!got || sb.size() == 0) $display("FAIL bp_second_rsp got timeout want response");
        else begin
            e = sb.pop_front();
            if (s !== e) $display("FAIL bp_second_rsp got %0h want %0h", s, e); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok, got;
        exp_t e, s;
        int rose;
        send(32'h100, 32'h1, 3'd0, 32'h101, 1'b0, ok);
        reset = 1'b1;
        #1;
        checks++; if ({cmd_ready, rsp_valid, busy, alu_a, alu_b, alu_opcode, rsp_result, rsp_zero, rsp_op} !== '0)
            $display("FAIL midreset_outputs got busy=%b a=%0h v=%b want all 0", busy, alu_a, rsp_valid); else passes++;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rose = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) rose++;
        end
        checks++; if (rose != 0) $display("FAIL midreset_no_rsp got %0d want 0", rose); else passes++;
        send(32'd20, 32'd4, 3'd1, 32'd16, 1'b0, ok);
        wait_rsp(got, s);
        checks++;
        if (!ok || !got || sb.size() == 0) $display("FAIL midreset_next got timeout want response");
        else begin
            e = sb.pop_front();
            if (s !== e) $display("FAIL midreset_next got %0h want %0h", s, e); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok, got;
        exp_t e, s;
        logic [W-1:0] a, b;
        logic [OW-1:0] op;
        for (int n = 0; n < 8; n++) begin
            a = $urandom; b = (n % 3 == 0) ? a : $urandom;
            op = OW'($urandom_range(0, 7));
            send(a, b, op, alu_fn(a, b, op), alu_fn(a, b, op) == '0, ok);
            wait_rsp(got, s);
            checks++;
            if (!ok || !got || sb.size() == 0) $display("FAIL b2b_%0d got timeout want response", n);
            else begin
                e = sb.pop_front();
                if (s !== e) $display("FAIL b2b_%0d got %0h want %0h", n, s, e); else passes++;
            end
        end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        bit ok, got;
        exp_t s;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        send(32'd5, 32'd5, 3'd1, 32'd0, 1'b1, ok); wait_rsp(got, s);
        send(32'd3, 32'd4, 3'd0, 32'd7, 1'b0, ok); wait_rsp(got, s);
        send(32'd7, 32'd7, 3'd1, 32'd0, 1'b1, ok); wait_rsp(got, s);
        sb.delete();
        checks++; if (stat_ops !== 16'd3) $display("FAIL stat_ops got %0d want 3", stat_ops); else passes++;
        checks++; if (stat_zero !== 16'd2) $display("FAIL stat_zero got %0d want 2", stat_zero); else passes++;
        force dut.stat_ops = 16'hFFFF;
        @(negedge clk);
        release dut.stat_ops;
        send(32'd1, 32'd2, 3'd0, 32'd3, 1'b0, ok); wait_rsp(got, s);
        sb.delete();
        checks++; if (stat_ops !== 16'hFFFF) $display("FAIL stat_sat got %0h want ffff", stat_ops); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_add_latency();
        test_sub_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
